// File: rtl/aasd_down_timer.sv
// Loadable down-counter/timer: counts toward zero and flags expiry with a tc pulse and a done level.
// Latency: count/tc/done/running are all registered and update together on the same core_clk edge.
// Backpressure: none; enable=0 freezes the timer, and load takes priority over enable.
//
// Ports:
//   core_clk     system clock, all state changes on posedge
//   arst_n       asynchronous active-low reset
//   enable       count enable; low holds count, state and prescale counter
//   load         synchronous load strobe (works regardless of enable)
//   data         load value, also captured as the reload value
//   auto_reload  1 = periodic, 0 = one-shot; sampled only on the terminal tick
//   prescale     tick divider (only used when PRESCALE_EN is defined)
//   count        current count
//   tc           terminal-count pulse, one cycle per expiry
//   done         high in DONE (one-shot expired) until next load/reset
//   running      high while in RUN
//
// Build option: define PRESCALE_EN to divide ticks by (prescale+1) enabled cycles.
module aasd_down_timer #(
  parameter int WIDTH     = 8,
  parameter int PRE_WIDTH = 4
) (
  input  logic                 core_clk,
  input  logic                 arst_n,
  input  logic                 enable,
  input  logic                 load,
  input  logic [WIDTH-1:0]     data,
  input  logic                 auto_reload,
  input  logic [PRE_WIDTH-1:0] prescale,
  output logic [WIDTH-1:0]     count,
  output logic                 tc,
  output logic                 done,
  output logic                 running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload_reg;
  logic             tick;

`ifdef PRESCALE_EN
  logic [PRE_WIDTH-1:0] pre_cnt;

  // One tick per (prescale+1) enabled RUN cycles.
  assign tick = enable && (state == RUN) && (pre_cnt == prescale);

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      pre_cnt <= '0;
    end else if (load) begin
      pre_cnt <= '0;
    end else if (enable && (state == RUN)) begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end
`else
  assign tick = enable && (state == RUN);

  // Divider input has no function in this build.
  logic [PRE_WIDTH-1:0] unused_prescale;
  assign unused_prescale = prescale;
`endif

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
      done       <= 1'b0;
      running    <= 1'b0;
    end else if (load) begin
      count      <= data;
      reload_reg <= data;
      tc         <= 1'b0;
      done       <= 1'b0;
      // Loading zero parks the timer; there is nothing to count down.
      if (data != '0) begin
        state   <= RUN;
        running <= 1'b1;
      end else begin
        state   <= IDLE;
        running <= 1'b0;
      end
    end else begin
      tc <= 1'b0;
      if (tick) begin
        // RUN is only entered with a non-zero count, so count==1 is always
        // reached before zero and the terminal path never lets it wrap.
        if (count > WIDTH'(1)) begin
          count <= count - 1'b1;
        end else if (auto_reload) begin
          count <= reload_reg;
          tc    <= 1'b1;
        end else begin
          count   <= '0;
          tc      <= 1'b1;
          state   <= DONE;
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aasd_down_timer.sv
module tb_aasd_down_timer;

  logic       core_clk;
  logic       arst_n;
  logic       enable;
  logic       load;
  logic [7:0] data;
  logic       auto_reload;
  logic [3:0] prescale;
  logic [7:0] count;
  logic       tc;
  logic       done;
  logic       running;

  aasd_down_timer #(.WIDTH(8), .PRE_WIDTH(4)) dut (
    .core_clk   (core_clk),
    .arst_n     (arst_n),
    .enable     (enable),
    .load       (load),
    .data       (data),
    .auto_reload(auto_reload),
    .prescale   (prescale),
    .count      (count),
    .tc         (tc),
    .done       (done),
    .running    (running)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  typedef struct {
    logic [7:0] count;
    logic       tc;
    logic       done;
    logic       running;
    int         seq;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   seq_no = 0;

  // Reference model: the timer as "ticks left until expiry" plus a phase.
  int m_phase;   // 0 = parked, 1 = timing, 2 = expired
  int m_left;
  int m_period;
  int m_div;     // enabled cycles seen since the last tick

  task automatic m_reset();
    m_phase = 0; m_left = 0; m_period = 0; m_div = 0;
  endtask

  task automatic m_step(input bit rst, input bit en, input bit ld, input int d,
                        input bit ar, input int ps, output exp_t e);
    bit pulse = 0;
    if (rst) begin
      m_reset();
    end else if (ld) begin
      m_left = d; m_period = d; m_div = 0;
      m_phase = (d != 0) ? 1 : 0;
    end else if (m_phase == 1 && en) begin
      bit fire;
`ifdef PRESCALE_EN
      fire  = (m_div == ps);
      m_div = fire ? 0 : (m_div + 1) % 16;
`else
      fire = 1;
`endif
      if (fire) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          pulse = 1;
          if (ar) m_left = m_period;
          else    m_phase = 2;
        end
      end
    end
    e.count   = m_left[7:0];
    e.tc      = pulse;
    e.done    = (m_phase == 2);
    e.running = (m_phase == 1);
    e.seq     = seq_no;
  endtask

  // One stimulus cycle: drive at negedge, predict the post-posedge outputs.
  task automatic cyc(input bit rst, input bit en, input bit ld, input int d,
                     input bit ar, input int ps);
    exp_t e;
    @(negedge core_clk);
    arst_n      = !rst;
    enable      = en;
    load        = ld;
    data        = d[7:0];
    auto_reload = ar;
    prescale    = ps[3:0];
    m_step(rst, en, ld, d, ar, ps, e);
    exp_q.push_back(e);
    seq_no++;
  endtask

  task automatic run(input int n, input bit en, input bit ar, input int ps);
    for (int i = 0; i < n; i++) cyc(0, en, 0, 0, ar, ps);
  endtask

  // Monitor: every posedge that follows a stimulus cycle has one expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge core_clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (count !== e.count || tc !== e.tc || done !== e.done || running !== e.running) begin
          n_bad++;
          $display("FAIL cycle%0d: got count=%0d tc=%b done=%b running=%b, want count=%0d tc=%b done=%b running=%b",
                   e.seq, count, tc, done, running, e.count, e.tc, e.done, e.running);
        end
      end
    end
  end

  task automatic chk_async(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ar_r, ps_r;
    arst_n = 1'b0; enable = 0; load = 0; data = 0; auto_reload = 0; prescale = 0;
    m_reset();

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);

    // Mid-run async reset with count at 5
    cyc(0, 1, 1, 8, 0, 0);
    run(3, 1, 0, 0);
    @(negedge core_clk);
    #2;
    arst_n = 1'b0;
    #1;
    chk_async("async_count",   count,        8'd0);
    chk_async("async_tc",      {7'd0, tc},   8'd0);
    chk_async("async_done",    {7'd0, done}, 8'd0);
    chk_async("async_running", {7'd0, running}, 8'd0);
    m_reset();
    cyc(1, 1, 0, 0, 0, 0);
    run(3, 1, 0, 0);                  // released, no load: stays parked at 0

    // One-shot 3,2,1,0 then hold in DONE
    cyc(0, 1, 1, 3, 0, 0);
    run(14, 1, 0, 0);

    // Auto-reload period 4
    cyc(0, 1, 1, 4, 1, 0);
    run(13, 1, 1, 0);

    // Enable gating, load with enable low, load of zero
    cyc(0, 1, 1, 4, 0, 0);
    run(2, 1, 0, 0);
    run(3, 0, 0, 0);
    run(2, 1, 0, 0);
    cyc(0, 0, 1, 8'hfa, 0, 0);
    run(2, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    run(3, 1, 0, 0);

    // Restart from DONE
    cyc(0, 1, 1, 1, 0, 0);
    run(3, 1, 0, 0);
    cyc(0, 1, 1, 2, 0, 0);
    run(5, 1, 0, 0);

    // Period of one: tc on every tick
    cyc(0, 1, 1, 1, 1, 0);
    run(4, 1, 1, 0);
    // auto_reload dropped mid-run only matters at the terminal tick
    cyc(0, 1, 1, 5, 1, 0);
    run(2, 1, 0, 0);
    run(6, 1, 0, 0);

    // Divider: prescale 2, load 2, then with an enable gap
    cyc(0, 1, 1, 2, 0, 2);
    run(8, 1, 0, 2);
    cyc(0, 1, 1, 2, 0, 2);
    run(2, 1, 0, 2);
    run(3, 0, 0, 2);
    run(6, 1, 0, 2);

    // Randomized traffic
    ar_r = 0; ps_r = 0;
    for (int i = 0; i < 3000; i++) begin
      bit rst, en, ld;
      int d;
      rst = ($urandom_range(0, 399) == 0);
      en  = ($urandom_range(0, 9) < 8);
      ld  = ($urandom_range(0, 13) == 0);
      d   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
      if ($urandom_range(0, 19) == 0) ar_r = $urandom_range(0, 1);
      if ($urandom_range(0, 49) == 0) ps_r = $urandom_range(0, 3);
      cyc(rst, en, ld, d, ar_r[0], ps_r);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge core_clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
